// File: rtl/mod_counter_updn_if.sv
// Control and status bundle for the up/down modulo counter.
// The master side drives the count controls; the slave side (the counter)
// returns the count value and its status flags.
interface mod_counter_updn_if #(
  parameter int WIDTH = 5
);
  logic             en;
  logic             up_dn;
  logic             sat_mode;
  logic [WIDTH-1:0] max_val;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, up_dn, sat_mode, max_val, load, load_val, clr_ovf,
    input  q, tc, wrap, ovf
  );

  modport slave (
    input  en, up_dn, sat_mode, max_val, load, load_val, clr_ovf,
    output q, tc, wrap, ovf
  );
endinterface

// File: rtl/mod_counter_updn.sv
// Up/down modulo counter with a runtime terminal value, wrap or saturate
// behaviour at the bounds, parallel load, a combinational terminal count
// for cascading, a one-cycle wrap pulse and a sticky overflow flag.
module mod_counter_updn #(
  parameter int              WIDTH       = 5,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_counter_updn_if.slave    ctr_io
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             bound_hit;

  logic at_top;
  logic at_zero;
  logic above_max;

  assign at_top    = (q_q >= ctr_io.max_val);
  assign at_zero   = (q_q == '0);
  assign above_max = (q_q > ctr_io.max_val);

  // Next-state selection: load beats count; bound events raise wrap/ovf.
  always_comb begin
    q_d       = q_q;
    wrap_d    = 1'b0;
    bound_hit = 1'b0;
    if (ctr_io.load) begin
      // Clamp into range; a clamp is not treated as a bound event.
      q_d = (ctr_io.load_val > ctr_io.max_val) ? ctr_io.max_val : ctr_io.load_val;
    end else if (ctr_io.en) begin
      if (ctr_io.up_dn) begin
        if (!at_top) begin
          q_d = q_q + 1'b1;
        end else begin
          // Also covers q above a freshly lowered max_val.
          bound_hit = 1'b1;
          if (ctr_io.sat_mode) begin
            q_d = ctr_io.max_val;
          end else begin
            q_d    = '0;
            wrap_d = 1'b1;
          end
        end
      end else begin
        if (at_zero) begin
          bound_hit = 1'b1;
          if (!ctr_io.sat_mode) begin
            q_d    = ctr_io.max_val;
            wrap_d = 1'b1;
          end
        end else if (above_max) begin
          // Out of range after max_val was lowered: pull back silently.
          q_d = ctr_io.max_val;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
    // Setting wins over a simultaneous clear.
    ovf_d = (ovf_q & ~ctr_io.clr_ovf) | bound_hit;
  end

  // State registers with synchronous reset overriding everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RESET_VALUE;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ctr_io.q    = q_q;
  assign ctr_io.wrap = wrap_q;
  assign ctr_io.ovf  = ovf_q;
  // Terminal count is combinational so a following stage sees it this cycle.
  assign ctr_io.tc   = ctr_io.en & ((ctr_io.up_dn & at_top) | (~ctr_io.up_dn & at_zero));

endmodule

// File: tb/tb_mod_counter_updn.sv
// Directed bench for mod_counter_updn (WIDTH=5, RESET_VALUE=0).
module tb_mod_counter_updn;
  localparam int WIDTH = 5;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mod_counter_updn_if #(.WIDTH(WIDTH)) ctr_if ();

  mod_counter_updn #(.WIDTH(WIDTH), .RESET_VALUE(5'd0)) dut (
    .clk    (clk),
    .rst    (rst),
    .ctr_io (ctr_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic up, input logic sat,
                       input logic [WIDTH-1:0] mx, input logic ld,
                       input logic [WIDTH-1:0] lv, input logic clr);
    ctr_if.en       = en;
    ctr_if.up_dn    = up;
    ctr_if.sat_mode = sat;
    ctr_if.max_val  = mx;
    ctr_if.load     = ld;
    ctr_if.load_val = lv;
    ctr_if.clr_ovf  = clr;
    #1;
  endtask

  // Load a value with counting disabled, no ovf clear.
  task automatic do_load(input logic [WIDTH-1:0] mx, input logic [WIDTH-1:0] lv);
    drive(1'b0, 1'b1, 1'b0, mx, 1'b1, lv, 1'b0);
    step();
  endtask

  int unsigned exp_q;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 5'd25, 1'b0, 5'd0, 1'b0);
    step();
    step();
    check("reset_q", ctr_if.q, 0);
    check("reset_wrap", ctr_if.wrap, 0);
    check("reset_ovf", ctr_if.ovf, 0);
    rst = 1'b0;

    // Mod-26 up count for 30 cycles.
    drive(1'b1, 1'b1, 1'b0, 5'd25, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      exp_q = i % 26;
      check($sformatf("m26_q[%0d]", i), ctr_if.q, exp_q);
      check($sformatf("m26_tc[%0d]", i), ctr_if.tc, (exp_q == 25) ? 1 : 0);
      step();
      check($sformatf("m26_wrap[%0d]", i), ctr_if.wrap, (exp_q == 25) ? 1 : 0);
    end
    check("m26_end_q", ctr_if.q, 4);
    check("m26_ovf", ctr_if.ovf, 1);

    // Down wrap, then clear.
    do_load(5'd25, 5'd2);
    check("dn_load_q", ctr_if.q, 2);
    drive(1'b0, 1'b0, 1'b0, 5'd25, 1'b0, 5'd0, 1'b1);
    step();
    check("dn_preclr_ovf", ctr_if.ovf, 0);
    drive(1'b1, 1'b0, 1'b0, 5'd25, 1'b0, 5'd0, 1'b0);
    step(); check("dn_q1", ctr_if.q, 1);  check("dn_w1", ctr_if.wrap, 0);
    check("dn_tc_at0_pre", ctr_if.tc, 0);
    step(); check("dn_q0", ctr_if.q, 0);  check("dn_w0", ctr_if.wrap, 0);
    check("dn_tc_at0", ctr_if.tc, 1);
    step(); check("dn_q25", ctr_if.q, 25); check("dn_w25", ctr_if.wrap, 1);
    step(); check("dn_q24", ctr_if.q, 24); check("dn_w24", ctr_if.wrap, 0);
    check("dn_ovf", ctr_if.ovf, 1);
    drive(1'b0, 1'b0, 1'b0, 5'd25, 1'b0, 5'd0, 1'b1);
    step();
    check("dn_clr_ovf", ctr_if.ovf, 0);
    check("dn_hold_q", ctr_if.q, 24);

    // Saturation up then down.
    do_load(5'd25, 5'd24);
    drive(1'b1, 1'b1, 1'b1, 5'd25, 1'b0, 5'd0, 1'b0);
    step(); check("sat_q1", ctr_if.q, 25); check("sat_w1", ctr_if.wrap, 0);
    check("sat_ovf_early", ctr_if.ovf, 0);
    check("sat_tc", ctr_if.tc, 1);
    step(); check("sat_q2", ctr_if.q, 25); check("sat_w2", ctr_if.wrap, 0);
    step(); check("sat_q3", ctr_if.q, 25); check("sat_w3", ctr_if.wrap, 0);
    check("sat_ovf", ctr_if.ovf, 1);
    do_load(5'd25, 5'd0);
    drive(1'b1, 1'b0, 1'b1, 5'd25, 1'b0, 5'd0, 1'b0);
    step(); check("satdn_q1", ctr_if.q, 0); check("satdn_w1", ctr_if.wrap, 0);
    step(); check("satdn_q2", ctr_if.q, 0); check("satdn_w2", ctr_if.wrap, 0);

    // Load priority over count, with clamp.
    drive(1'b1, 1'b1, 1'b0, 5'd25, 1'b1, 5'd31, 1'b0);
    step();
    check("ld_clamp_q", ctr_if.q, 25);
    check("ld_clamp_wrap", ctr_if.wrap, 0);
    check("ld_clamp_ovf", ctr_if.ovf, 1);
    drive(1'b1, 1'b1, 1'b0, 5'd25, 1'b1, 5'd10, 1'b0);
    step();
    check("ld10_q", ctr_if.q, 10);
    drive(1'b0, 1'b1, 1'b0, 5'd25, 1'b0, 5'd0, 1'b0);
    step();
    check("hold_q", ctr_if.q, 10);

    // Runtime max reduction.
    do_load(5'd25, 5'd20);
    drive(1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0);
    check("rmax_up_tc", ctr_if.tc, 1);
    step();
    check("rmax_up_q", ctr_if.q, 0);
    check("rmax_up_wrap", ctr_if.wrap, 1);
    do_load(5'd25, 5'd20);
    drive(1'b0, 1'b1, 1'b0, 5'd25, 1'b0, 5'd0, 1'b1);
    step();
    check("rmax_preclr", ctr_if.ovf, 0);
    drive(1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0);
    step();
    check("rmax_dn_q", ctr_if.q, 7);
    check("rmax_dn_wrap", ctr_if.wrap, 0);
    check("rmax_dn_ovf", ctr_if.ovf, 0);

    // Reset beats load/en at a wrapping edge.
    do_load(5'd25, 5'd25);
    drive(1'b1, 1'b1, 1'b0, 5'd25, 1'b0, 5'd0, 1'b0);
    step();
    check("pre_rst_ovf", ctr_if.ovf, 1);
    do_load(5'd25, 5'd25);
    drive(1'b1, 1'b1, 1'b0, 5'd25, 1'b1, 5'd3, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_q", ctr_if.q, 0);
    check("rst_wrap", ctr_if.wrap, 0);
    check("rst_ovf", ctr_if.ovf, 0);

    // clr_ovf coinciding with a wrap: set wins.
    do_load(5'd25, 5'd25);
    drive(1'b1, 1'b1, 1'b0, 5'd25, 1'b0, 5'd0, 1'b1);
    step();
    check("setclr_q", ctr_if.q, 0);
    check("setclr_wrap", ctr_if.wrap, 1);
    check("setclr_ovf", ctr_if.ovf, 1);

    // max_val == 0: continuous wraps.
    drive(1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(); check("m0_q1", ctr_if.q, 0); check("m0_w1", ctr_if.wrap, 1);
    step(); check("m0_q2", ctr_if.q, 0); check("m0_w2", ctr_if.wrap, 1);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(); check("m0_hold_w", ctr_if.wrap, 0);
    check("m0_hold_tc", ctr_if.tc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mod_counter_updn.md
Name: mod_counter_updn

Overview:
- Parametrised successor to the fixed mod-26 up-counter.
- Up/down modulo counter with:
  - runtime-programmable terminal value;
  - wrap or saturate mode;
  - synchronous parallel load;
  - count enable;
  - combinational terminal-count output for cascading;
  - registered wrap pulse;
  - sticky overflow flag.
- Used standalone for timing dividers/sequencers, or chained (tc -> next stage en) to build wider counters.

Parameters:
- WIDTH, 5, counter width in bits.
- RESET_VALUE, 0, value loaded into q on reset; must be <= 2^WIDTH-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; counting occurs only on cycles where en=1.
- up_dn  input  1  direction: 1=count up, 0=count down.
- sat_mode  input  1  1=saturate at bounds, 0=wrap.
- max_val  input  WIDTH  terminal value; counting range is 0..max_val inclusive.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- clr_ovf  input  1  clears sticky overflow flag.
- q  output  WIDTH  registered count.
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle pulse after a wrap.
- ovf  output  1  sticky overflow/saturation-attempt flag.

Behaviour:
- Reset (rst=1 at clock edge):
  - q <= RESET_VALUE; wrap <= 0; ovf <= 0.
  - rst overrides load, en and clr_ovf.
- Priority per cycle: rst > load > en. When en=0 and load=0, q holds.
- Load:
  - q <= min(load_val, max_val).
  - No wrap pulse and no ovf change, even if clamped.
  - Load with en=1 ignores the count.
- Count up (en=1, up_dn=1):
  - q < max_val: q <= q+1.
  - q >= max_val, wrap mode: q <= 0; wrap <= 1; ovf <= 1.
  - q >= max_val, sat mode: q <= max_val; ovf <= 1; no wrap pulse.
- Count down (en=1, up_dn=0):
  - 0 < q <= max_val: q <= q-1.
  - q == 0, wrap mode: q <= max_val; wrap <= 1; ovf <= 1.
  - q == 0, sat mode: q holds 0; ovf <= 1.
  - q > max_val (max_val lowered at runtime): q <= max_val; no flags.
- Up-count when q > max_val falls under the q >= max_val rule, so the counter re-enters range in one enabled cycle.
- tc = en & ((up_dn & (q >= max_val)) | (~up_dn & (q == 0))).
  - Purely combinational, no clock latency.
  - Asserted regardless of sat_mode.
- wrap:
  - High exactly one cycle, the cycle after the wrapping edge.
  - Otherwise 0, including during load and hold.
  - Back-to-back wraps (e.g. max_val=0, en=1) hold wrap=1 continuously.
- ovf:
  - Set by any bound event (wrap or saturation attempt).
  - Cleared by clr_ovf.
  - Set and clear in the same cycle: set wins.
- max_val == 0:
  - Wrap mode: q stays 0; every enabled cycle wraps.
  - Sat mode: q stays 0; ovf sets on the first enabled cycle.
- Arithmetic:
  - Unsigned, WIDTH bits; no intermediate wider than WIDTH+1.
  - max_val = 2^WIDTH-1 gives full natural-range counting.
- Reset mid-count: q returns to RESET_VALUE on that edge; any pending wrap pulse is suppressed.
- up_dn, sat_mode and max_val may change on any cycle and take effect on that cycle's edge.

Test Plan (WIDTH=5, RESET_VALUE=0 unless stated):
- Mod-26 up count: max_val=25, wrap mode, en=1, up_dn=1 for 30 cycles from reset.
  - q runs 0..25 then 0..3.
  - tc=1 only while q=25.
  - wrap=1 the cycle q returns to 0.
  - ovf=1 afterwards.
- Down wrap then clear:
  - load_val=2, then down-count.
  - q runs 2,1,0,25,24.
  - wrap pulses once after the 0->25 step.
  - clr_ovf then drops ovf to 0 on the next edge.
- Saturation:
  - sat_mode=1, max_val=25, load 24, count up 3 cycles.
  - q runs 25,25,25; wrap never asserts; ovf=1.
  - Then down-count from 0 for 2 cycles: q stays 0.
- Load priority and clamp:
  - load=1, en=1, load_val=31, max_val=25: q=25 next cycle, no wrap, ovf unchanged.
  - load_val=10: q=10.
- Runtime max reduction:
  - q=20, set max_val=7, up-count: q=0 with wrap=1.
  - Repeat with q=20 and down-count: q=7 with no wrap and no ovf.
- Reset and simultaneous events:
  - rst asserted with load=1, en=1, q=25 (up): q=RESET_VALUE, wrap=0, ovf=0.
  - Separately, clr_ovf=1 in the same cycle as a wrap: ovf remains 1.
